// File: rtl/descrambler_66_if.sv
// Block stream between the RX gearbox, the 64b/66b descrambler and the decoder,
// together with the descrambler's error/status outputs.
interface descrambler_66_if #(
  parameter int unsigned CNT_W = 16
);
  logic [65:0]      din;
  logic             din_valid;
  logic             word_locked;
  logic             cnt_clear;
  logic [65:0]      dout;
  logic             dout_valid;
  logic             hdr_err;
  logic             type_err;
  logic             ber_high;
  logic [CNT_W-1:0] hdr_err_cnt;
  logic [CNT_W-1:0] type_err_cnt;

  modport master (
    output din, din_valid, word_locked, cnt_clear,
    input  dout, dout_valid, hdr_err, type_err, ber_high, hdr_err_cnt, type_err_cnt
  );

  modport slave (
    input  din, din_valid, word_locked, cnt_clear,
    output dout, dout_valid, hdr_err, type_err, ber_high, hdr_err_cnt, type_err_cnt
  );
endinterface

// File: rtl/descrambler_66.sv
// 64b/66b self-synchronous descrambler (x^58 + x^39 + 1) with sync-header and
// block-type checking, saturating error counters and a windowed BER monitor.
module descrambler_66 #(
  parameter int unsigned WINDOW     = 1024,
  parameter int unsigned BER_THRESH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  descrambler_66_if.slave bus
);

  localparam int unsigned BLK_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned ERR_W = $clog2(BER_THRESH + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(WINDOW - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(BER_THRESH);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t            state, state_next;
  logic [57:0]       sreg;
  logic [121:0]      x;
  logic [63:0]       plain;
  logic              hdr_bad, type_bad;
  logic [65:0]       dout_q;
  logic              dout_valid_q, hdr_err_q, type_err_q, ber_high_q, ber_next;
  logic [CNT_W-1:0]  hdr_cnt_q, type_cnt_q;
  logic [BLK_W-1:0]  blk_cnt, blk_next;
  logic [ERR_W-1:0]  win_err, werr_next, werr_inc;

  function automatic logic type_legal(input logic [7:0] t);
    case (t)
      8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
      8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // sreg[57] is the newest scrambled bit, so x is one continuous bit history.
  always_comb begin
    x = {bus.din[65:2], sreg};
    plain = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      plain[i] = x[58+i] ^ x[19+i] ^ x[i];
    end
  end

  always_comb begin
    hdr_bad  = bus.word_locked && (bus.din[1:0] == 2'b00 || bus.din[1:0] == 2'b11);
    type_bad = bus.word_locked && (bus.din[1:0] == 2'b01) && !type_legal(plain[7:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      hdr_err_q    <= 1'b0;
      type_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= bus.din_valid;
      hdr_err_q    <= bus.din_valid && hdr_bad;
      type_err_q   <= bus.din_valid && type_bad;
      if (bus.din_valid) begin
        dout_q <= {plain, bus.din[1:0]};
        sreg   <= bus.din[65:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt_q  <= '0;
      type_cnt_q <= '0;
    end else if (bus.cnt_clear) begin
      hdr_cnt_q  <= '0;
      type_cnt_q <= '0;
    end else begin
      if (bus.din_valid && hdr_bad && hdr_cnt_q != '1)
        hdr_cnt_q <= hdr_cnt_q + 1'b1;
      if (bus.din_valid && type_bad && type_cnt_q != '1)
        type_cnt_q <= type_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      blk_cnt    <= '0;
      win_err    <= '0;
      ber_high_q <= 1'b0;
    end else begin
      state      <= state_next;
      blk_cnt    <= blk_next;
      win_err    <= werr_next;
      ber_high_q <= ber_next;
    end
  end

  // The block that moves IDLE->COUNT is also the first block of the window.
  always_comb begin
    state_next = state;
    blk_next   = blk_cnt;
    werr_next  = win_err;
    ber_next   = ber_high_q;
    werr_inc   = (hdr_bad && win_err != ERR_MAX) ? win_err + 1'b1 : win_err;
    if (!bus.word_locked) begin
      state_next = IDLE;
      blk_next   = '0;
      werr_next  = '0;
    end else if (bus.din_valid) begin
      state_next = COUNT;
      if (blk_cnt == BLK_LAST) begin
        ber_next  = (werr_inc >= ERR_MAX);
        blk_next  = '0;
        werr_next = '0;
      end else begin
        blk_next  = blk_cnt + 1'b1;
        werr_next = werr_inc;
      end
    end
  end

  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.hdr_err      = hdr_err_q;
  assign bus.type_err     = type_err_q;
  assign bus.ber_high     = ber_high_q;
  assign bus.hdr_err_cnt  = hdr_cnt_q;
  assign bus.type_err_cnt = type_cnt_q;

endmodule

// File: tb/tb_descrambler_66.sv
// Self-checking bench for descrambler_66: bit-serial scrambler/descrambler
// reference plus counting model for flags, counters and the BER window.
module tb_descrambler_66;
  localparam int WIN = 64;
  localparam int TH  = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  descrambler_66_if #(.CNT_W(CW)) bus();

  descrambler_66 #(.WINDOW(WIN), .BER_THRESH(TH), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  logic [57:0] sc;   // reference scrambler history, [k] = k+1 bits ago
  logic [57:0] dh;   // reference descrambler history, same ordering
  logic [65:0] m_dout;
  logic        m_dv, m_he, m_te, m_ber;
  int          m_hc, m_tc, m_blk, m_werr;
  logic [7:0]  legal [15] = '{8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
                              8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  logic [65:0] a_din [200];
  logic [63:0] a_pl  [200];

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("dout_valid",   66'(bus.dout_valid),   66'(m_dv));
    chk("dout",         bus.dout,              m_dout);
    chk("hdr_err",      66'(bus.hdr_err),      66'(m_he));
    chk("type_err",     66'(bus.type_err),     66'(m_te));
    chk("ber_high",     66'(bus.ber_high),     66'(m_ber));
    chk("hdr_err_cnt",  66'(bus.hdr_err_cnt),  66'(m_hc));
    chk("type_err_cnt", 66'(bus.type_err_cnt), 66'(m_tc));
  endtask

  task automatic model_reset();
    dh = '0; m_dout = '0; m_dv = 1'b0; m_he = 1'b0; m_te = 1'b0; m_ber = 1'b0;
    m_hc = 0; m_tc = 0; m_blk = 0; m_werr = 0;
  endtask

  task automatic scramble(input logic [63:0] p, output logic [63:0] s);
    for (int b = 0; b < 64; b++) begin
      s[b] = p[b] ^ sc[38] ^ sc[57];
      sc = {sc[56:0], s[b]};
    end
  endtask

  task automatic descramble(input logic [63:0] s, output logic [63:0] p);
    for (int b = 0; b < 64; b++) begin
      p[b] = s[b] ^ dh[38] ^ dh[57];
      dh = {dh[56:0], s[b]};
    end
  endtask

  function automatic bit is_legal(input logic [7:0] t);
    foreach (legal[k]) if (legal[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mk(input logic [1:0] h, input logic [63:0] p, output logic [65:0] d);
    logic [63:0] s;
    scramble(p, s);
    d = {s, h};
  endtask

  // Drive one cycle, advance the model, then check all outputs after the edge.
  task automatic cyc(input logic [65:0] d, input logic v, input logic lk, input logic clr);
    logic [63:0] p;
    bit he, te;
    bus.din = d; bus.din_valid = v; bus.word_locked = lk; bus.cnt_clear = clr;
    he = 1'b0; te = 1'b0;
    if (v) begin
      descramble(d[65:2], p);
      he = lk && (d[1:0] == 2'b00 || d[1:0] == 2'b11);
      te = lk && (d[1:0] == 2'b01) && !is_legal(p[7:0]);
      m_dout = {p, d[1:0]};
    end
    m_dv = v; m_he = he; m_te = te;
    if (clr) begin
      m_hc = 0; m_tc = 0;
    end else begin
      if (he && m_hc < CMAX) m_hc++;
      if (te && m_tc < CMAX) m_tc++;
    end
    if (!lk) begin
      m_blk = 0; m_werr = 0;
    end else if (v) begin
      if (he && m_werr < TH) m_werr++;
      m_blk++;
      if (m_blk == WIN) begin
        m_ber = (m_werr >= TH);
        m_blk = 0; m_werr = 0;
      end
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset();
    bus.din = '0; bus.din_valid = 1'b0; bus.word_locked = 1'b1; bus.cnt_clear = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk); #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic run_window(input int nerr);
    logic [65:0] d;
    logic [1:0] h;
    for (int j = 0; j < WIN; j++) begin
      h = (j % 8 == 7 && j / 8 < nerr) ? ((j % 16 == 7) ? 2'b11 : 2'b00) : 2'b10;
      mk(h, {$urandom, $urandom}, d);
      cyc(d, 1'b1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] p;
    logic [65:0] d;
    logic [1:0]  h;
    logic [7:0]  t;

    #2 do_reset();

    // Continuous stream with two bad headers at blocks 50/51.
    sc = '1;
    for (int k = 0; k < 200; k++) begin
      p = {$urandom, $urandom};
      h = (k == 50) ? 2'b11 : (k == 51) ? 2'b00 : 2'b10;
      mk(h, p, d);
      a_din[k] = d; a_pl[k] = p;
      cyc(d, 1'b1, 1'b1, 1'b0);
      if (k >= 1) chk("plain_cont", 66'(bus.dout[65:2]), 66'(p));
    end
    chk("hdr_cnt_two", 66'(bus.hdr_err_cnt), 66'd2);
    cyc(66'($urandom), 1'b0, 1'b1, 1'b0);

    // Same stream, one valid in three cycles, junk on din during gaps.
    do_reset();
    for (int k = 0; k < 200; k++) begin
      cyc(a_din[k], 1'b1, 1'b1, 1'b0);
      if (k >= 1) chk("plain_gap", 66'(bus.dout[65:2]), 66'(a_pl[k]));
      cyc({$urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
      cyc({$urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    end
    chk("hdr_cnt_gap", 66'(bus.hdr_err_cnt), 66'd2);

    // Control block type checks.
    p = {$urandom, $urandom}; p[7:0] = 8'h1E; mk(2'b01, p, d); cyc(d, 1'b1, 1'b1, 1'b0);
    chk("type_1e", 66'(bus.type_err), 66'd0);
    p = {$urandom, $urandom}; p[7:0] = 8'h3C; mk(2'b01, p, d); cyc(d, 1'b1, 1'b1, 1'b0);
    chk("type_3c", 66'(bus.type_err), 66'd1);
    chk("type_cnt_one", 66'(bus.type_err_cnt), 66'd1);
    p[7:0] = 8'h3C; mk(2'b10, p, d); cyc(d, 1'b1, 1'b1, 1'b0);
    chk("type_data", 66'(bus.type_err), 66'd0);
    mk(2'b11, p, d); cyc(d, 1'b1, 1'b1, 1'b0);
    chk("type_badhdr", 66'(bus.type_err), 66'd0);
    for (int k = 0; k < 40; k++) begin
      p = {$urandom, $urandom};
      t = $urandom_range(0, 1) ? legal[$urandom_range(0, 14)] : 8'($urandom);
      p[7:0] = t;
      mk(2'b01, p, d);
      cyc(d, 1'b1, 1'b1, 1'b0);
    end

    // BER window boundaries: 4, 0, 4, 3 errors.
    do_reset();
    run_window(4); chk("ber_w1", 66'(bus.ber_high), 66'd1);
    run_window(0); chk("ber_w2", 66'(bus.ber_high), 66'd0);
    run_window(4); chk("ber_w3", 66'(bus.ber_high), 66'd1);
    run_window(3); chk("ber_w4", 66'(bus.ber_high), 66'd0);

    // Lock loss mid-window; window restarts from the relock block.
    for (int j = 0; j < 20; j++) begin
      mk((j == 3 || j == 9) ? 2'b11 : 2'b10, {$urandom, $urandom}, d);
      cyc(d, 1'b1, 1'b1, 1'b0);
    end
    for (int j = 0; j < 10; j++) begin
      mk(2'b11, {$urandom, $urandom}, d);
      cyc(d, 1'b1, 1'b0, 1'b0);
      chk("unlock_noflag", 66'(bus.hdr_err), 66'd0);
    end
    for (int j = 0; j < WIN; j++) begin
      mk((j >= 60) ? 2'b00 : 2'b10, {$urandom, $urandom}, d);
      cyc(d, 1'b1, 1'b1, 1'b0);
      if (j == 62) chk("relock_pre", 66'(bus.ber_high), 66'd0);
    end
    chk("relock_ber", 66'(bus.ber_high), 66'd1);
    for (int j = 0; j < 5; j++) begin
      mk(2'b10, {$urandom, $urandom}, d);
      cyc(d, 1'b1, 1'b0, 1'b0);
    end
    chk("ber_hold", 66'(bus.ber_high), 66'd1);

    // Counter clear priority and saturation.
    mk(2'b11, {$urandom, $urandom}, d); cyc(d, 1'b1, 1'b1, 1'b1);
    chk("clr_wins", 66'(bus.hdr_err_cnt), 66'd0);
    for (int j = 0; j < 20; j++) begin
      mk(2'b00, {$urandom, $urandom}, d);
      cyc(d, 1'b1, 1'b1, 1'b0);
    end
    chk("hdr_sat", 66'(bus.hdr_err_cnt), 66'(CMAX));

    // Asynchronous reset between edges discards the block in flight.
    mk(2'b11, {$urandom, $urandom}, d);
    bus.din = d; bus.din_valid = 1'b1; bus.word_locked = 1'b1; bus.cnt_clear = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    chk("async_cnt", 66'(bus.hdr_err_cnt), 66'd0);
    @(posedge clk); #1;
    check_outputs();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      mk(2'b10, {$urandom, $urandom}, d);
      cyc(d, 1'b1, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
